uart_cmd_parser: RTL
====================

Name: uart_cmd_parser

Overview:
- Sits directly downstream of the UART receiver behind the HC-06 Bluetooth link (9600 baud).
- Consumes the byte stream RxData/RxDone and assembles framed commands: SOF, CMD, LEN, payload, checksum.
- Validates length and checksum, and enforces an inter-byte timeout.
- Presents each complete, valid command to application logic as a one-cycle strobe with held Cmd/Len/Payload.

Parameters:
- MAX_LEN, 4, maximum payload bytes accepted (1..15).
- TIMEOUT_CYC, 500000, Clk cycles allowed between bytes inside a frame (10 ms at 50 MHz).
- SOF_BYTE, 8'hA5, start-of-frame marker.

Ports:
- Clk  in  1  system clock.
- Rst_n  in  1  synchronous active-low reset.
- RxData  in  8  byte from UART receiver; valid while RxDone high.
- RxDone  in  1  receiver done flag; may stay high for several cycles.
- CmdValid  out  1  one-cycle pulse: new valid frame on Cmd/Len/Payload.
- Cmd  out  8  command byte of last valid frame.
- Len  out  4  payload length of last valid frame.
- Payload  out  8*MAX_LEN  payload bytes; byte i occupies bits [8i+7:8i]; bytes at index >= Len read 0.
- ErrChk  out  1  one-cycle pulse: checksum mismatch.
- ErrLen  out  1  one-cycle pulse: LEN > MAX_LEN.
- ErrTimeout  out  1  one-cycle pulse: inter-byte timeout.
- Busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-low on Rst_n. Every register clears on the first Clk edge with Rst_n low, including a reset mid-frame. Reset values of all outputs are 0; state resets to IDLE.
- Byte event: RxDone rising edge, detected against a registered copy of RxDone. One event per byte, regardless of how long RxDone stays high. RxData is sampled in the event cycle.
- Checksum: 8-bit XOR over CMD, LEN and all payload bytes. The frame's final byte must equal that XOR.
- State machine (5 states):
  - IDLE: on event with RxData == SOF_BYTE -> CMD and clear the work buffer. Any other byte is ignored, no error.
  - CMD: on event, store Cmd_w, seed chk = byte, go to LEN.
  - LEN: on event with byte[7:0] > MAX_LEN -> pulse ErrLen, go to IDLE. With byte == 0 -> CHK. Otherwise store Len_w = byte[3:0], idx = 0, go to DATA. Every non-error path does chk ^= byte.
  - DATA: on event, buf[idx] = byte, chk ^= byte. If idx == Len_w-1 go to CHK, else idx++.
  - CHK: on event with byte == chk, copy Cmd_w/Len_w/buf to Cmd/Len/Payload and pulse CmdValid, go to IDLE. With byte != chk, pulse ErrChk, go to IDLE, and leave outputs unchanged.
- Latency: CmdValid, ErrChk and ErrLen assert on the Clk edge after the event cycle of the deciding byte.
- Output holding: Cmd/Len/Payload change only on a valid frame. A partial or erroneous frame never disturbs them.
- SOF inside a frame is treated as ordinary data (no resync); only the timeout or an error returns the parser to IDLE.
- Timeout:
  - Counter clears on every byte event and while IDLE, and increments otherwise.
  - When the count reaches TIMEOUT_CYC-1 in a non-IDLE state: pulse ErrTimeout, go to IDLE.
  - If a byte event and timeout expiry land in the same cycle, the byte wins and no timeout fires.
  - Counter width is clog2(TIMEOUT_CYC); it saturates and never wraps.
- At most one of CmdValid/ErrChk/ErrLen/ErrTimeout is high in any cycle.
- Busy = (state != IDLE), registered.

Decomposition:
- Package uart_cmd_pkg holds:
  - the state enum (IDLE, CMD, LEN, DATA, CHK);
  - the default SOF constant 8'hA5;
  - the error-code localparams.
- One sub-module, uart_byte_timeout: counter with clear input (byte event or IDLE), enable, and an expired pulse, parameterised by TIMEOUT_CYC. The FSM, datapath and edge detector stay in uart_cmd_parser.

Test Plan:
- Valid frame: send A5 10 02 33 44 (chk = 10^02^33^44 = 65) followed by 65 -> CmdValid pulses once; Cmd=10, Len=2, Payload=32'h0000_4433; no error pulses.
- Bad checksum: A5 20 01 7F then 00 (correct value is 5E) -> ErrChk pulses once; Cmd/Len/Payload keep their values from the previous frame.
- Length overflow with MAX_LEN=4: A5 30 05 -> ErrLen pulses after the LEN byte; the next bytes 01 02 are ignored until a new A5 arrives.
- Timeout with TIMEOUT_CYC=100: send A5 40, then idle for 100 cycles -> ErrTimeout pulses once, Busy falls. A later byte 40 arriving at the exact expiry cycle must suppress the timeout.
- RxDone held high for 5 cycles per byte, plus a zero-length frame A5 07 00 07 -> exactly one event per byte; CmdValid with Cmd=07, Len=0, Payload=0.
- Rst_n low for one cycle mid-payload of A5 50 03 11 -> all outputs 0, state IDLE. A following full valid frame is accepted normally.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command parser.
//   state_t      : parser FSM states
//   SOF_DEFAULT  : default start-of-frame marker
//   ERR_*        : error codes carried in the registered error field
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    LEN  = 3'd2,
    DATA = 3'd3,
    CHK  = 3'd4
  } state_t;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CHK     = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/uart_byte_timeout.sv
// Inter-byte timeout counter.
// Ports:
//   clk     : system clock
//   rst_n   : synchronous active-low reset
//   clear   : restart the count (byte event or parser idle); overrides expiry
//   enable  : count while the parser is inside a frame
//   expired : high in the cycle the count sits at TIMEOUT_CYC-1 with no clear
module uart_byte_timeout #(
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  // Saturates at LAST; the parser leaves its frame on expiry, so the
  // expired flag lasts a single cycle in practice.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/uart_cmd_parser.sv
// Framed command parser behind the UART receiver.
// Frame: SOF, CMD, LEN, LEN payload bytes, XOR checksum over CMD..payload.
// Ports:
//   Clk, Rst_n  : clock, synchronous active-low reset
//   RxData      : received byte, valid while RxDone is high
//   RxDone      : receiver done flag; only its rising edge counts
//   CmdValid    : one-cycle strobe, Cmd/Len/Payload hold a new frame
//   Cmd/Len     : command and payload length of the last valid frame
//   Payload     : byte i at [8i+7:8i], unused bytes read 0
//   ErrChk/ErrLen/ErrTimeout : one-cycle error strobes
//   Busy        : parser is inside a frame
//
// state | meaning
// IDLE  | waiting for SOF_BYTE
// CMD   | next byte is the command
// LEN   | next byte is the payload length
// DATA  | collecting payload bytes
// CHK   | next byte is the checksum
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int         MAX_LEN     = 4,
  parameter int         TIMEOUT_CYC = 500000,
  parameter logic [7:0] SOF_BYTE    = SOF_DEFAULT
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic [7:0]           RxData,
  input  logic                 RxDone,
  output logic                 CmdValid,
  output logic [7:0]           Cmd,
  output logic [3:0]           Len,
  output logic [8*MAX_LEN-1:0] Payload,
  output logic                 ErrChk,
  output logic                 ErrLen,
  output logic                 ErrTimeout,
  output logic                 Busy
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t               state;
  logic                 rx_done_q;
  logic                 byte_evt;
  logic                 tmo_expired;
  logic [7:0]           cmd_w;
  logic [3:0]           len_w;
  logic [3:0]           idx;
  logic [7:0]           chk;
  logic [8*MAX_LEN-1:0] work_buf;
  logic [1:0]           err_q;

  assign byte_evt = RxDone && !rx_done_q;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      rx_done_q <= 1'b0;
    end else begin
      rx_done_q <= RxDone;
    end
  end

  uart_byte_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (Clk),
    .rst_n  (Rst_n),
    .clear  (byte_evt || (state == IDLE)),
    .enable (state != IDLE),
    .expired(tmo_expired)
  );

  // A single registered error code makes the three error strobes
  // mutually exclusive by construction.
  assign ErrChk     = (err_q == ERR_CHK);
  assign ErrLen     = (err_q == ERR_LEN);
  assign ErrTimeout = (err_q == ERR_TIMEOUT);

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state    <= IDLE;
      Busy     <= 1'b0;
      CmdValid <= 1'b0;
      err_q    <= ERR_NONE;
      Cmd      <= '0;
      Len      <= '0;
      Payload  <= '0;
      cmd_w    <= '0;
      len_w    <= '0;
      idx      <= '0;
      chk      <= '0;
      work_buf <= '0;
    end else begin
      CmdValid <= 1'b0;
      err_q    <= ERR_NONE;
      // Expiry cannot coincide with a byte event: the event clears the timer.
      if (tmo_expired) begin
        state <= IDLE;
        Busy  <= 1'b0;
        err_q <= ERR_TIMEOUT;
      end else if (byte_evt) begin
        case (state)
          IDLE: begin
            if (RxData == SOF_BYTE) begin
              state    <= CMD;
              Busy     <= 1'b1;
              work_buf <= '0;
            end
          end
          CMD: begin
            cmd_w <= RxData;
            chk   <= RxData;
            state <= LEN;
          end
          LEN: begin
            if (RxData > MAX_LEN_B) begin
              err_q <= ERR_LEN;
              state <= IDLE;
              Busy  <= 1'b0;
            end else begin
              chk   <= chk ^ RxData;
              len_w <= RxData[3:0];
              idx   <= '0;
              state <= (RxData == 8'd0) ? CHK : DATA;
            end
          end
          DATA: begin
            for (int i = 0; i < MAX_LEN; i++) begin
              if (idx == 4'(i)) work_buf[8*i +: 8] <= RxData;
            end
            chk <= chk ^ RxData;
            if (idx == len_w - 4'd1) begin
              state <= CHK;
            end else begin
              idx <= idx + 4'd1;
            end
          end
          CHK: begin
            if (RxData == chk) begin
              Cmd      <= cmd_w;
              Len      <= len_w;
              Payload  <= work_buf;
              CmdValid <= 1'b1;
            end else begin
              err_q <= ERR_CHK;
            end
            state <= IDLE;
            Busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
